// File: rtl/calculator_alu.sv
// Multi-cycle ALU behind the calculator core: single-cycle ADD/SUB, iterative shift-add MUL
// and restoring DIV on operand magnitudes, with overflow / divide-by-zero reporting.
module calculator_alu #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_alu_input_a,
    input  logic [DATA_WIDTH-1:0] i_alu_input_b,
    input  logic [1:0]            i_alu_input_op,
    input  logic                  i_alu_input_signed,
    input  logic                  i_alu_input_valid,
    output logic                  o_alu_input_ready,
    output logic [DATA_WIDTH-1:0] o_alu_result,
    output logic                  o_alu_error,
    output logic                  o_alu_result_valid,
    input  logic                  i_alu_result_ready
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [2*W-1:0] MAG_MIN = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]   Q_MIN   = {1'b1, {(W-1){1'b0}}};

    // Both handshakes: a transfer happens on the clk edge where valid && ready are both 1.
    // The request side is ready only in IDLE; the result side holds valid and data until taken.
    typedef enum logic [2:0] {IDLE, ADDSUB, ITER, FIXUP, DONE} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [1:0]       r_op;
    logic             r_signed;
    logic [CW-1:0]    r_cnt;
    logic             r_prep;
    logic [W-1:0]     r_mag_a;
    logic [W-1:0]     r_mag_b;
    logic [2*W-1:0]   r_acc;
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_result;
    logic             r_error;
    logic             r_valid;

    logic             w_accept;
    logic [W:0]       w_sum;
    logic [W:0]       w_diff;
    logic [W-1:0]     w_as_res;
    logic             w_as_err;
    logic [2*W-1:0]   w_mul_next;
    logic [W:0]       w_rem_shift;
    logic             w_rem_ge;
    logic [W-1:0]     w_rem_next;
    logic             w_neg;
    logic             w_fx_err;
    logic [W-1:0]     w_fx_res;

    function automatic logic [W-1:0] f_neg(input logic [W-1:0] x);
        return ~x + W'(1);
    endfunction

    function automatic logic [W-1:0] f_mag(input logic [W-1:0] x, input logic s);
        return (s && x[W-1]) ? f_neg(x) : x;
    endfunction

    assign o_alu_input_ready  = (r_state == IDLE);
    assign o_alu_result       = r_result;
    assign o_alu_error        = r_error;
    assign o_alu_result_valid = r_valid;

    assign w_accept = i_alu_input_valid && (r_state == IDLE);
    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff   = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_as_res = r_op[0] ? w_diff[W-1:0] : w_sum[W-1:0];
        if (r_op[0]) begin
            w_as_err = r_signed ? ((r_a[W-1] != r_b[W-1]) && (w_diff[W-1] != r_a[W-1])) : w_diff[W];
        end else begin
            w_as_err = r_signed ? ((r_a[W-1] == r_b[W-1]) && (w_sum[W-1] != r_a[W-1])) : w_sum[W];
        end
    end

    // One bit per cycle, MSB first: the counter indexes the multiplier / dividend bit.
    assign w_mul_next  = {r_acc[2*W-2:0], 1'b0}
                       + (r_mag_b[r_cnt] ? {{W{1'b0}}, r_mag_a} : {(2*W){1'b0}});
    assign w_rem_shift = {r_rem, r_mag_a[r_cnt]};
    assign w_rem_ge    = (w_rem_shift >= {1'b0, r_mag_b});
    assign w_rem_next  = w_rem_ge ? (w_rem_shift[W-1:0] - r_mag_b) : w_rem_shift[W-1:0];

    always_comb begin
        w_neg = r_signed && (r_a[W-1] ^ r_b[W-1]);
        if (!r_op[0]) begin
            w_fx_err = r_signed ? (w_neg ? (r_acc > MAG_MIN) : (r_acc >= MAG_MIN))
                                : (|r_acc[2*W-1:W]);
        end else begin
            w_fx_err = (r_b == '0) || (r_signed && !w_neg && (r_acc[W-1:0] == Q_MIN));
        end
        w_fx_res = w_fx_err ? '0 : (w_neg ? f_neg(r_acc[W-1:0]) : r_acc[W-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = i_alu_input_op[1] ? ITER : ADDSUB;
            ADDSUB:  w_next_state = DONE;
            ITER:    if (!r_prep && (r_cnt == '0)) w_next_state = FIXUP;
            FIXUP:   w_next_state = DONE;
            DONE:    if (i_alu_result_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
            r_prep   <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a      <= i_alu_input_a;
                        r_b      <= i_alu_input_b;
                        r_op     <= i_alu_input_op;
                        r_signed <= i_alu_input_signed;
                        r_cnt    <= CW'(W - 1);
                        r_prep   <= 1'b1;
                    end
                end
                ADDSUB: begin
                    r_result <= w_as_err ? '0 : w_as_res;
                    r_error  <= w_as_err;
                    r_valid  <= 1'b1;
                end
                ITER: begin
                    // First ITER cycle converts the latched operands to magnitudes.
                    if (r_prep) begin
                        r_mag_a <= f_mag(r_a, r_signed);
                        r_mag_b <= f_mag(r_b, r_signed);
                        r_acc   <= '0;
                        r_rem   <= '0;
                        r_prep  <= 1'b0;
                    end else begin
                        if (!r_op[0]) begin
                            r_acc <= w_mul_next;
                        end else begin
                            r_acc <= {r_acc[2*W-2:0], w_rem_ge};
                            r_rem <= w_rem_next;
                        end
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                FIXUP: begin
                    r_result <= w_fx_res;
                    r_error  <= w_fx_err;
                    r_valid  <= 1'b1;
                end
                DONE: begin
                    if (i_alu_result_ready) r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calculator_alu.sv
// Directed and random checks of calculator_alu: results, error flags, latency,
// backpressure and asynchronous reset during an iterative operation.
module tb_calculator_alu;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         sgn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] result;
    logic         error;
    logic         res_valid;
    logic         res_ready;

    int           checks = 0;
    int           errors = 0;
    logic [W:0]   exp_q[$];
    logic [1:0]   cur_op;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [1:0]   rop;
    logic         rs;
    logic         saw_valid;

    calculator_alu #(.DATA_WIDTH(W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_alu_input_a      (a),
        .i_alu_input_b      (b),
        .i_alu_input_op     (op),
        .i_alu_input_signed (sgn),
        .i_alu_input_valid  (in_valid),
        .o_alu_input_ready  (in_ready),
        .o_alu_result       (result),
        .o_alu_error        (error),
        .o_alu_result_valid (res_valid),
        .i_alu_result_ready (res_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic [1:0] mop, input logic ms);
        longint sa, sb, r, lo, hi;
        logic   err;
        if (ms) begin
            sa = longint'($signed(ma));
            sb = longint'($signed(mb));
            lo = -(longint'(1) << (W - 1));
            hi = (longint'(1) << (W - 1)) - 1;
        end else begin
            sa = longint'(ma);
            sb = longint'(mb);
            lo = 0;
            hi = (longint'(1) << W) - 1;
        end
        err = 1'b0;
        r   = 0;
        case (mop)
            2'd0:    r = sa + sb;
            2'd1:    r = sa - sb;
            2'd2:    r = sa * sb;
            default: if (sb == 0) err = 1'b1; else r = sa / sb;
        endcase
        if (r < lo || r > hi) err = 1'b1;
        return err ? {1'b1, {W{1'b0}}} : {1'b0, r[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] top,
                            input logic ts, input logic [W:0] exp, input bit track, input bit junk);
        @(negedge clk);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb;
        op       = top;
        sgn      = ts;
        in_valid = 1'b1;
        cur_op   = top;
        if (track) exp_q.push_back(exp);
        @(negedge clk);
        if (junk) begin
            a   = W'($urandom);
            b   = W'($urandom);
            op  = 2'($urandom);
            sgn = 1'($urandom);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic finish_op(input int hold, input string tag);
        int         lat;
        logic [W:0] exp;
        lat = 0;
        while (res_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 32'(lat), cur_op[1] ? 32'(W + 2) : 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, {W{1'b1}}};
        check({tag, "_result"}, 32'(result), 32'(exp[W-1:0]));
        check({tag, "_error"}, 32'(error), 32'(exp[W]));
        check({tag, "_busy_in_done"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
            check({tag, "_hold_result"}, 32'(result), 32'(exp[W-1:0]));
            check({tag, "_hold_error"}, 32'(error), 32'(exp[W]));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_cleared"}, 32'(res_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        sgn       = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        cur_op    = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_valid", 32'(res_valid), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        rst_n = 1'b1;

        start_op(16'h1234, 16'h0001, 2'b00, 1'b0, {1'b0, 16'h1235}, 1'b1, 1'b0);
        finish_op(0, "add_u");
        start_op(16'hFFFF, 16'h0001, 2'b00, 1'b0, {1'b1, 16'h0000}, 1'b1, 1'b0);
        finish_op(0, "add_u_carry");
        start_op(16'hFFFD, 16'h0007, 2'b10, 1'b1, {1'b0, 16'hFFEB}, 1'b1, 1'b0);
        finish_op(0, "mul_s");
        start_op(16'h0100, 16'h0100, 2'b10, 1'b0, {1'b1, 16'h0000}, 1'b1, 1'b0);
        finish_op(0, "mul_u_ovf");
        start_op(16'hFFF9, 16'h0002, 2'b11, 1'b1, {1'b0, 16'hFFFD}, 1'b1, 1'b0);
        finish_op(0, "div_s");
        start_op(16'h8000, 16'hFFFF, 2'b11, 1'b1, {1'b1, 16'h0000}, 1'b1, 1'b0);
        finish_op(0, "div_s_min");
        start_op(16'h0005, 16'h0000, 2'b11, 1'b0, {1'b1, 16'h0000}, 1'b1, 1'b0);
        finish_op(0, "div_u_zero");
        start_op(16'h0005, 16'h0000, 2'b11, 1'b1, {1'b1, 16'h0000}, 1'b1, 1'b0);
        finish_op(0, "div_s_zero");
        start_op(16'h7FFF, 16'h0001, 2'b00, 1'b1, {1'b1, 16'h0000}, 1'b1, 1'b0);
        finish_op(0, "add_s_ovf");
        start_op(16'h8000, 16'h0001, 2'b01, 1'b1, {1'b1, 16'h0000}, 1'b1, 1'b0);
        finish_op(0, "sub_s_ovf");
        start_op(16'h0003, 16'h0005, 2'b01, 1'b0, {1'b1, 16'h0000}, 1'b1, 1'b0);
        finish_op(0, "sub_u_borrow");
        start_op(16'hFF00, 16'h0080, 2'b10, 1'b1, {1'b0, 16'h8000}, 1'b1, 1'b0);
        finish_op(0, "mul_s_min");
        start_op(16'h0100, 16'h0080, 2'b10, 1'b1, {1'b1, 16'h0000}, 1'b1, 1'b0);
        finish_op(0, "mul_s_pos_ovf");
        start_op(16'h8000, 16'h0001, 2'b11, 1'b1, {1'b0, 16'h8000}, 1'b1, 1'b0);
        finish_op(0, "div_s_min_by_1");
        start_op(16'hFFFF, 16'h0003, 2'b11, 1'b0, {1'b0, 16'h5555}, 1'b1, 1'b1);
        finish_op(0, "div_u_junk_in");
        res_ready = 1'b1;
        start_op(16'hFFFE, 16'h0003, 2'b10, 1'b1, {1'b0, 16'hFFFA}, 1'b1, 1'b0);
        finish_op(0, "mul_s_early_ready");
        start_op(16'h1111, 16'h2222, 2'b00, 1'b0, {1'b0, 16'h3333}, 1'b1, 1'b1);
        finish_op(5, "add_backpressure");

        for (int i = 0; i < 20; i++) begin
            ra  = W'($urandom_range(0, 16'hFFFF));
            rb  = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 16'hFFFF)) : W'($urandom_range(0, 300));
            rop = 2'($urandom_range(0, 3));
            rs  = 1'($urandom_range(0, 1));
            start_op(ra, rb, rop, rs, model(ra, rb, rop, rs), 1'b1, 1'b0);
            finish_op($urandom_range(0, 2), "rand");
        end

        start_op(16'h0003, 16'h0005, 2'b01, 1'b1, {1'b0, 16'hFFFE}, 1'b1, 1'b0);
        finish_op(0, "sub_s");

        start_op(16'h0123, 16'h0456, 2'b10, 1'b0, '0, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        check("mid_mul_busy", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_result", 32'(result), 32'd0);
        check("async_rst_error", 32'(error), 32'd0);
        check("async_rst_valid", 32'(res_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        saw_valid = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (res_valid === 1'b1) saw_valid = 1'b1;
        end
        check("no_stale_result", 32'(saw_valid), 32'd0);
        start_op(16'h0002, 16'h0003, 2'b00, 1'b0, {1'b0, 16'h0005}, 1'b1, 1'b0);
        finish_op(0, "add_after_reset");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/calculator_alu.md
Name: calculator_alu

Overview:
- Multi-cycle arithmetic unit directly downstream of the calculator core.
- Accepts one operation (A, B, op, signed flag) per valid/ready handshake.
- ADD/SUB complete in one cycle; MUL uses iterative shift-add, DIV uses restoring division.
- Returns a DATA_WIDTH result plus error flag over a second valid/ready handshake that the core consumes into register A.

Parameters:
DATA_WIDTH, 16, operand/result width in bits; must be >= 4.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
i_alu_input_a  input  DATA_WIDTH  operand A
i_alu_input_b  input  DATA_WIDTH  operand B
i_alu_input_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
i_alu_input_signed  input  1  1: two's-complement operands/result; 0: unsigned
i_alu_input_valid  input  1  operation request valid
o_alu_input_ready  output  1  unit can accept an operation
o_alu_result  output  DATA_WIDTH  result; 0 whenever o_alu_error=1
o_alu_error  output  1  overflow / divide-by-zero flag
o_alu_result_valid  output  1  result valid
i_alu_result_ready  input  1  consumer accepts result

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low; its polarity and synchronicity are fixed.
- States: IDLE, ADDSUB, ITER, FIXUP, DONE.
- Reset (asynchronous, also mid-operation): state=IDLE, o_alu_result=0, o_alu_error=0, o_alu_result_valid=0. Any in-flight operation is discarded; no result is emitted.
- o_alu_input_ready=1 exactly when state==IDLE (combinational from state). It is 1 during and right after reset.
- Accept: on a clk edge with valid&&ready, latch A, B, op, signed into internal registers. Inputs are ignored at all other times.
- IDLE->ADDSUB for op 0x; IDLE->ITER for op 1x. Counter loads DATA_WIDTH-1.
- ADDSUB (1 cycle): compute the result and error, then go to DONE. Result valid is visible 1 cycle after the accept edge.
- ITER runs DATA_WIDTH cycles, one quotient/product bit per cycle:
  - MUL: operates on operand magnitudes, 2*DATA_WIDTH-bit accumulator.
  - DIV: operates on magnitudes, restoring algorithm, remainder discarded.
  - When the counter reaches 0, go to FIXUP.
- FIXUP (1 cycle): apply the sign, evaluate error, go to DONE. MUL/DIV latency is DATA_WIDTH+2 cycles from the accept edge (18 at default).
- DONE: o_alu_result_valid=1. Result and error are held stable until valid&&i_alu_result_ready. The handshake edge goes to IDLE and clears valid.
- No new input is accepted in the same cycle as a result handshake. Ready rises the cycle after.
- Magnitude of a signed operand: two's-complement negate if MSB=1. 0x8000 gives magnitude 0x8000 as unsigned DATA_WIDTH+1 bits.
- Error rules (on error, o_alu_result=0):
  - ADD unsigned: carry out of MSB. ADD signed: operands share a sign and the sum sign differs.
  - SUB unsigned: A<B (borrow). SUB signed: operand signs differ and the result sign differs from A.
  - MUL unsigned: any nonzero bit in the upper DATA_WIDTH product bits.
  - MUL signed: result negative (sign(A) xor sign(B), product nonzero) with magnitude > 2^(W-1), or result positive with magnitude > 2^(W-1)-1.
  - DIV: B==0 is an error in both modes. It still takes full DIV latency and is detected in FIXUP.
  - DIV signed: truncates toward zero. Quotient magnitude 2^(W-1) with positive sign (MIN/-1) is an error.
- Zero results are never negative (no -0 concern in two's complement; a negated 0 stays 0).
- i_alu_result_ready high while not in DONE has no effect.
- i_alu_input_valid dropping while not ready has no effect.

Test Plan:
- Unsigned ADD: A=0x1234, B=0x0001, op=00, signed=0 -> result 0x1235, error 0, result_valid 1 cycle after accept. Then A=0xFFFF, B=0x0001 -> result 0x0000, error 1.
- Signed MUL: A=0xFFFD (-3), B=0x0007, op=10, signed=1 -> result 0xFFEB (-21), error 0, valid exactly 18 cycles after accept. Unsigned A=0x0100, B=0x0100 -> error 1, result 0.
- Signed DIV: A=0xFFF9 (-7), B=0x0002 -> 0xFFFD (-3), error 0. A=0x8000, B=0xFFFF -> error 1. A=0x0005, B=0x0000 (either mode) -> error 1, result 0, latency 18.
- Signed ADD/SUB overflow: 0x7FFF+0x0001 -> error 1. Signed 0x8000-0x0001 -> error 1. Unsigned SUB 0x0003-0x0005 -> error 1. Signed SUB 0x0003-0x0005 -> 0xFFFE, error 0.
- Backpressure: hold i_alu_result_ready=0 for 5 cycles in DONE. Result, error and valid stay constant and o_alu_input_ready=0. Raise ready -> valid drops next cycle, input ready 1 the cycle after handshake.
- Reset mid-MUL: assert rst_n=0 at iteration 7 -> outputs zero immediately (async), ready=1. After release, no stale result appears; a fresh ADD 0x0002+0x0003 returns 0x0005.
